// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: buffers a commanded payload, then sends header/payload/parity
// honouring busy and reports the router err outcome. Optional `PARITY_INJ_EN adds inj_err (inverted parity).
module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       pl_vld,
  input  logic [7:0] pl_data,
  output logic       pl_rdy,
  input  logic       busy,
  input  logic       err,
`ifdef PARITY_INJ_EN
  input  logic       inj_err,
`endif
  output logic       pkt_vld,
  output logic [7:0] din,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int WCW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HDR, S_PLD, S_PAR, S_CHK, S_DONE} state_t;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_hdr, w_hdr;
  logic [5:0]     r_len, w_len;
  logic [5:0]     r_cnt, w_cnt;
  logic [7:0]     r_par, w_par;
  logic           r_flag, w_flag;
  logic [WCW-1:0] r_wcnt, w_wcnt;
  logic           r_cmd_rdy, w_cmd_rdy;
  logic           r_pl_rdy, w_pl_rdy;
  logic           r_pkt_vld, w_pkt_vld;
  logic [7:0]     r_din, w_din;
  logic           r_tx_done, w_tx_done;
  logic           r_tx_err, w_tx_err;
  logic           w_wr;
  logic           w_cmd_ok;
  logic [7:0]     w_inv;
  logic [7:0]     r_buf [MAX_LEN];

`ifdef PARITY_INJ_EN
  logic r_inj, w_inj;
  assign w_inv = {8{r_inj}};
`else
  assign w_inv = '0;
`endif

  assign w_cmd_ok = (cmd_len != '0) && (cmd_addr != 2'd3) && (32'(cmd_len) <= MAX_LEN);

  // Outputs are registered from the next-state values, so each one lines up with the state it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_hdr       = r_hdr;
    w_len       = r_len;
    w_cnt       = r_cnt;
    w_par       = r_par;
    w_flag      = r_flag;
    w_wcnt      = r_wcnt;
    w_pkt_vld   = r_pkt_vld;
    w_din       = r_din;
    w_tx_err    = 1'b0;
    w_wr        = 1'b0;
`ifdef PARITY_INJ_EN
    w_inj       = r_inj;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_cmd_rdy && cmd_vld) begin
          if (w_cmd_ok) begin
            w_hdr       = {cmd_len, cmd_addr};
            w_len       = cmd_len;
            w_cnt       = '0;
            w_par       = '0;
            w_flag      = 1'b0;
`ifdef PARITY_INJ_EN
            w_inj       = inj_err;
`endif
            w_state_nxt = S_LOAD;
          end else begin
            w_tx_err    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (r_pl_rdy && pl_vld) begin
          w_wr = 1'b1;
          if (r_cnt == r_len - 6'd1) begin
            w_cnt       = '0;
            w_pkt_vld   = 1'b1;
            w_din       = r_hdr;
            w_state_nxt = S_HDR;
          end else begin
            w_cnt = r_cnt + 6'd1;
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          w_par       = r_par ^ r_din;
          w_din       = r_buf[0];
          w_state_nxt = S_PLD;
        end
      end
      S_PLD: begin
        if (!busy) begin
          w_par = r_par ^ r_din;
          if (r_cnt == r_len - 6'd1) begin
            w_pkt_vld   = 1'b0;
            w_din       = (r_par ^ r_din) ^ w_inv;
            w_state_nxt = S_PAR;
          end else begin
            w_cnt = r_cnt + 6'd1;
            w_din = r_buf[r_cnt + 6'd1];
          end
        end
      end
      S_PAR: begin
        if (err) w_flag = 1'b1;
        if (!busy) begin
          w_wcnt      = '0;
          w_din       = '0;
          w_state_nxt = S_CHK;
        end
      end
      S_CHK: begin
        if (err) w_flag = 1'b1;
        if (r_wcnt == WCW'(ERR_WAIT - 1)) begin
          w_tx_err    = r_flag | err;
          w_state_nxt = S_DONE;
        end else begin
          w_wcnt = r_wcnt + 1'b1;
        end
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_cmd_rdy = (w_state_nxt == S_IDLE);
    w_pl_rdy  = (w_state_nxt == S_LOAD);
    w_tx_done = (w_state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hdr     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_par     <= '0;
      r_flag    <= 1'b0;
      r_wcnt    <= '0;
      r_cmd_rdy <= 1'b0;
      r_pl_rdy  <= 1'b0;
      r_pkt_vld <= 1'b0;
      r_din     <= '0;
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
`ifdef PARITY_INJ_EN
      r_inj     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_hdr     <= w_hdr;
      r_len     <= w_len;
      r_cnt     <= w_cnt;
      r_par     <= w_par;
      r_flag    <= w_flag;
      r_wcnt    <= w_wcnt;
      r_cmd_rdy <= w_cmd_rdy;
      r_pl_rdy  <= w_pl_rdy;
      r_pkt_vld <= w_pkt_vld;
      r_din     <= w_din;
      r_tx_done <= w_tx_done;
      r_tx_err  <= w_tx_err;
`ifdef PARITY_INJ_EN
      r_inj     <= w_inj;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_cnt] <= pl_data;
  end

  assign cmd_rdy = r_cmd_rdy;
  assign pl_rdy  = r_pl_rdy;
  assign pkt_vld = r_pkt_vld;
  assign din     = r_din;
  assign tx_done = r_tx_done;
  assign tx_err  = r_tx_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: queue-based packet model checked every cycle, plus directed literals.
module tb_router_pkt_tx;

  localparam int MAX_LEN  = 63;
  localparam int ERR_WAIT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_vld = 1'b0;
  logic       cmd_rdy;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic       pl_vld = 1'b0;
  logic [7:0] pl_data = '0;
  logic       pl_rdy;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic       inj_d = 1'b0;
  logic       pkt_vld;
  logic [7:0] din;
  logic       tx_done;
  logic       tx_err;

  int total = 0;
  int bad   = 0;

  int   busy_pct = 0;
  int   err_pct  = 0;
  logic busy_dir = 1'b0;
  logic err_dir  = 1'b0;

  logic [7:0] pdata[$];
  logic [8:0] plog[$];

  router_pkt_tx #(.MAX_LEN(MAX_LEN), .ERR_WAIT(ERR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .pl_vld(pl_vld), .pl_data(pl_data), .pl_rdy(pl_rdy),
    .busy(busy), .err(err),
`ifdef PARITY_INJ_EN
    .inj_err(inj_d),
`endif
    .pkt_vld(pkt_vld), .din(din), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Router-side stimulus: random, or directed by the main thread, applied just after each negedge.
  always @(negedge clk) begin
    #1;
    busy = (busy_pct > 0) ? ($urandom_range(99) < busy_pct) : busy_dir;
    err  = (err_pct  > 0) ? ($urandom_range(99) < err_pct)  : err_dir;
  end

  // Reference model: the packet is a queue of {pkt_vld,byte} that drains one entry per non-busy edge.
  typedef enum int {M_IDLE, M_LOAD, M_SEND, M_WAIT, M_DONE} mode_t;
  mode_t      m_mode = M_IDLE;
  logic       e_cmd_rdy = 0, e_pl_rdy = 0, e_pkt_vld = 0, e_tx_done = 0, e_tx_err = 0;
  logic [7:0] e_din = '0;
  logic [7:0] m_hdr, m_par;
  int         m_len, m_wait;
  logic       m_flag, m_inj;
  logic [7:0] m_plq[$];
  logic [8:0] m_txq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE;
      {e_cmd_rdy, e_pl_rdy, e_pkt_vld, e_tx_done, e_tx_err} = '0;
      e_din = '0;
      m_plq.delete();
      m_txq.delete();
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (e_cmd_rdy && cmd_vld) begin
            e_cmd_rdy = 0;
            if (cmd_len == 0 || cmd_addr == 3 || int'(cmd_len) > MAX_LEN) begin
              m_mode = M_DONE; e_tx_done = 1; e_tx_err = 1;
            end else begin
              m_len = int'(cmd_len); m_hdr = {cmd_len, cmd_addr}; m_inj = inj_d;
              m_plq.delete(); m_mode = M_LOAD; e_pl_rdy = 1;
            end
          end else e_cmd_rdy = 1;
        end
        M_LOAD: begin
          if (pl_vld) begin
            m_plq.push_back(pl_data);
            if (m_plq.size() == m_len) begin
              m_par = m_hdr;
              m_txq.delete();
              m_txq.push_back({1'b1, m_hdr});
              foreach (m_plq[k]) begin
                m_par = m_par ^ m_plq[k];
                m_txq.push_back({1'b1, m_plq[k]});
              end
              if (m_inj) m_par = ~m_par;
              m_txq.push_back({1'b0, m_par});
              {e_pkt_vld, e_din} = m_txq[0];
              e_pl_rdy = 0; m_flag = 0; m_mode = M_SEND;
            end
          end
        end
        M_SEND: begin
          if (err && m_txq.size() == 1) m_flag = 1;
          if (!busy) begin
            void'(m_txq.pop_front());
            if (m_txq.size() == 0) begin
              m_mode = M_WAIT; m_wait = ERR_WAIT; e_pkt_vld = 0; e_din = '0;
            end else {e_pkt_vld, e_din} = m_txq[0];
          end
        end
        M_WAIT: begin
          if (err) m_flag = 1;
          m_wait--;
          if (m_wait == 0) begin m_mode = M_DONE; e_tx_done = 1; e_tx_err = m_flag; end
        end
        M_DONE: begin
          e_tx_done = 0; e_tx_err = 0; e_cmd_rdy = 1; m_mode = M_IDLE;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    check("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, e_cmd_rdy});
    check("pl_rdy",  {31'd0, pl_rdy},  {31'd0, e_pl_rdy});
    check("pkt_vld", {31'd0, pkt_vld}, {31'd0, e_pkt_vld});
    check("din",     {24'd0, din},     {24'd0, e_din});
    check("tx_done", {31'd0, tx_done}, {31'd0, e_tx_done});
    check("tx_err",  {31'd0, tx_err},  {31'd0, e_tx_err});
  end

  // Sends one command + payload from pdata and waits for tx_done; logs every pkt_vld cycle plus the parity cycle.
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj, input int stall_n,
                         input int err_k, input int rst_at, input int gap_pct,
                         output logic got_err, output int done_cyc);
    int   i, n0, stalls;
    logic prev_vld;
    bit   rdy;
    plog.delete();
    got_err = 1'b0; done_cyc = -1; rdy = 0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (cmd_rdy) begin rdy = 1; break; end
    end
    if (!rdy) begin check("cmd_rdy_timeout", 32'd0, 32'd1); return; end
    cmd_vld = 1'b1; cmd_addr = a; cmd_len = l; inj_d = inj;
    i = 0; n0 = -1; prev_vld = 1'b0; stalls = stall_n;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 0) cmd_vld = 1'b0;
      if (tx_done) begin
        got_err = tx_err; done_cyc = c + 1;
        pl_vld = 1'b0; busy_dir = 1'b0; err_dir = 1'b0;
        return;
      end
      if (pkt_vld || prev_vld) plog.push_back({pkt_vld, din});
      if (!pkt_vld && prev_vld) n0 = c;
      prev_vld = pkt_vld;
      if (rst_at >= 0 && pkt_vld && plog.size() == rst_at + 2) begin
        pl_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_async_pkt_vld", {31'd0, pkt_vld}, 32'd0);
        check("rst_async_din", {24'd0, din}, 32'd0);
        done_cyc = -2;
        return;
      end
      busy_dir = (stalls > 0 && pkt_vld && din == 8'h22);
      if (busy_dir) stalls--;
      err_dir = (n0 >= 0 && err_k >= 0 && c == n0 + err_k);
      if (pl_rdy && i < int'(l) && $urandom_range(99) >= gap_pct) begin
        pl_vld = 1'b1; pl_data = pdata[i]; i++;
      end else if (pl_rdy) begin
        pl_vld = 1'b0; pl_data = 8'($urandom);
      end else begin
        pl_vld = 1'($urandom_range(1)); pl_data = 8'($urandom);
      end
    end
    check("tx_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_log(input string nm, input logic [8:0] exp[$]);
    check({nm, "_len"}, plog.size(), exp.size());
    foreach (exp[k]) if (k < plog.size()) check(nm, {23'd0, plog[k]}, {23'd0, exp[k]});
  endtask

  initial begin
    logic       ge;
    int         dc;
    logic [5:0] l;
    logic [8:0] exp[$];

    repeat (2) @(negedge clk);
    check("reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
    check("reset_pkt_vld", {31'd0, pkt_vld}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

    // Basic packet: header {3,1}=0x0D, parity 0x0D^0x11^0x22^0x33=0x0D
    pdata = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd1, 6'd3, 1'b0, 0, -1, -1, 0, ge, dc);
    exp = '{9'h10D, 9'h111, 9'h122, 9'h133, 9'h00D};
    check_log("basic_seq", exp);
    check("basic_tx_err", {31'd0, ge}, 32'd0);

    // Four busy cycles while 0x22 is on din
    run_pkt(2'd1, 6'd3, 1'b0, 4, -1, -1, 0, ge, dc);
    exp = '{9'h10D, 9'h111, 9'h122, 9'h122, 9'h122, 9'h122, 9'h122, 9'h133, 9'h00D};
    check_log("stall_seq", exp);
    check("stall_tx_err", {31'd0, ge}, 32'd0);

    run_pkt(2'd1, 6'd3, 1'b0, 0, 2, -1, 0, ge, dc);
    check("err_in_window", {31'd0, ge}, 32'd1);
    run_pkt(2'd1, 6'd3, 1'b0, 0, 5, -1, 0, ge, dc);
    check("err_after_window", {31'd0, ge}, 32'd0);

    run_pkt(2'd2, 6'd0, 1'b0, 0, -1, -1, 0, ge, dc);
    check("rej_len0_err", {31'd0, ge}, 32'd1);
    check("rej_len0_lat", dc, 32'd1);
    check("rej_len0_novld", plog.size(), 32'd0);
    @(negedge clk);
    check("rej_len0_rdy", {31'd0, cmd_rdy}, 32'd1);
    run_pkt(2'd3, 6'd5, 1'b0, 0, -1, -1, 0, ge, dc);
    check("rej_addr3_err", {31'd0, ge}, 32'd1);
    check("rej_addr3_lat", dc, 32'd1);
    check("rej_addr3_novld", plog.size(), 32'd0);
    @(negedge clk);
    check("rej_addr3_rdy", {31'd0, cmd_rdy}, 32'd1);

    pdata.delete();
    for (int k = 0; k < 20; k++) pdata.push_back(8'($urandom));
    run_pkt(2'd0, 6'd20, 1'b0, 0, -1, 10, 0, ge, dc);
    check("rst_mid_taken", dc, -32'sd2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    // header {1,2}=0x06, parity 0x06^0x5A=0x5C
    pdata = '{8'h5A};
    run_pkt(2'd2, 6'd1, 1'b0, 0, -1, -1, 0, ge, dc);
    exp = '{9'h106, 9'h15A, 9'h05C};
    check_log("after_rst_seq", exp);
    check("after_rst_tx_err", {31'd0, ge}, 32'd0);

`ifdef PARITY_INJ_EN
    // header 0x04, true parity 0xA1, transmitted ~0xA1 = 0x5E; router answers with err
    pdata = '{8'hA5};
    run_pkt(2'd0, 6'd1, 1'b1, 0, 1, -1, 0, ge, dc);
    exp = '{9'h104, 9'h1A5, 9'h05E};
    check_log("inj_seq", exp);
    check("inj_tx_err", {31'd0, ge}, 32'd1);
`endif

    busy_pct = 25; err_pct = 3;
    for (int p = 0; p < 40; p++) begin
      l = ($urandom_range(9) == 0) ? (($urandom_range(1) == 0) ? 6'd0 : 6'd63) : 6'($urandom_range(24, 1));
      pdata.delete();
      for (int k = 0; k < int'(l); k++) pdata.push_back(8'($urandom));
      run_pkt(2'($urandom_range(3)), l, 1'b0, 0, -1, -1, 30, ge, dc);
    end
    busy_pct = 0; err_pct = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
